// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sharing one single-port SRAM; optional macro ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              busy
);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              grant_d;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              grant;
   logic              done;
   logic              pick_d;
   logic              force_fetch;

`ifdef ARB_STARVE_GUARD_EN
   localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
   logic [STREAK_W-1:0] streak;

   assign force_fetch = (streak == STREAK_W'(STARVE_LIMIT)) && i_req && d_req;

   // Count data grants that beat a waiting fetch; any other grant clears the streak
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (grant) begin
         if (pick_d && i_req) begin
            streak <= streak + 1'b1;
         end else begin
            streak <= '0;
         end
      end
   end
`else
   assign force_fetch = 1'b0;
`endif

   // Data has priority unless the starvation guard hands this slot to fetch
   assign pick_d = d_req && !force_fetch;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and SRAM/handshake outputs
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      sram_cs   = 1'b0;
      sram_oe   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            busy      = 1'b1;
            sram_cs   = 1'b1;
            sram_oe   = !lat_we;
            sram_we   = lat_we;
            sram_addr = lat_addr;
            sram_din  = lat_wdata;
            if (wait_cnt == '0) begin
               done      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            busy      = 1'b1;
            i_ack     = !grant_d;
            d_ack     = grant_d;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner at grant, pace the access, capture read data at the last access cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_d   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         wait_cnt  <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant) begin
            grant_d   <= pick_d;
            lat_we    <= pick_d && d_we;
            lat_addr  <= pick_d ? d_addr : i_addr;
            lat_wdata <= pick_d ? d_wdata : '0;
            wait_cnt  <= CNT_W'(WAIT_CYCLES - 1);
         end else if (state == ACCESS && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (done && !lat_we) begin
            if (grant_d) begin
               d_rdata <= sram_dout;
            end else begin
               i_rdata <= sram_dout;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a memory-level model
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        i_req, i_ack, d_req, d_we, d_ack;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic        sram_cs, sram_oe, sram_we, busy;
   logic [31:0] sram_addr, sram_din, sram_dout;

   logic        w3_i_req, w3_i_ack, w3_d_req, w3_d_we, w3_d_ack;
   logic [31:0] w3_i_addr, w3_i_rdata, w3_d_addr, w3_d_wdata, w3_d_rdata;
   logic        w3_sram_cs, w3_sram_oe, w3_sram_we, w3_busy;
   logic [31:0] w3_sram_addr, w3_sram_din, w3_sram_dout;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
      .busy(busy)
   );

   mem_port_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .rst(rst),
      .i_req(w3_i_req), .i_addr(w3_i_addr), .i_ack(w3_i_ack), .i_rdata(w3_i_rdata),
      .d_req(w3_d_req), .d_we(w3_d_we), .d_addr(w3_d_addr), .d_wdata(w3_d_wdata),
      .d_ack(w3_d_ack), .d_rdata(w3_d_rdata),
      .sram_cs(w3_sram_cs), .sram_oe(w3_sram_oe), .sram_we(w3_sram_we),
      .sram_addr(w3_sram_addr), .sram_din(w3_sram_din), .sram_dout(w3_sram_dout),
      .busy(w3_busy)
   );

   // SRAM behind the main instance: 256 words, combinational read, write on clock edge
   logic [31:0] mem [256];
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      else if (sram_cs && sram_we) mem[sram_addr[7:0]] <= sram_din;
   end
   assign sram_dout    = mem[sram_addr[7:0]];
   assign w3_sram_dout = w3_sram_addr ^ 32'hC3C3_0000;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model [256];
   logic [7:0]  ia, da;
   logic [31:0] dwd, exp_i, exp_d;
   logic        dwe, i_pend, d_pend;
   int          i_cool, d_cool, i_wait, d_wait, n_ack, n_iack, n_we;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] v);
      load_addr = a;
      load_data = v;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      w3_i_req = 1'b0; w3_i_addr = '0; w3_d_req = 1'b0; w3_d_we = 1'b0;
      w3_d_addr = '0; w3_d_wdata = '0;
      for (int k = 0; k < 256; k++) load(8'(k), $urandom);
      load(8'h10, 32'hDEADBEEF);
      load(8'h20, 32'h0A0A0A0A);
      load(8'h30, 32'h5A5A1234);

      // Reset state
      step();
      chk("rst_acks", {i_ack, d_ack}, 0);
      chk("rst_rdata", {i_rdata, d_rdata}, 0);
      chk("rst_ctrl", {sram_cs, sram_oe, sram_we, busy}, 0);
      chk("rst_addr_din", {sram_addr, sram_din}, 0);
      rst = 1'b0;
      step();

      // Single fetch, WAIT_CYCLES=1
      i_req = 1'b1; i_addr = 32'h10;
      step();
      chk("fetch_c1_ctrl", {sram_cs, sram_oe, sram_we, i_ack, busy}, 5'b11001);
      chk("fetch_c1_addr", sram_addr, 32'h10);
      i_req = 1'b0;
      step();
      chk("fetch_c2_ack", {i_ack, d_ack, sram_cs}, 3'b100);
      chk("fetch_c2_rdata", i_rdata, 32'hDEADBEEF);
      step();
      chk("fetch_c3_idle", {i_ack, busy, sram_cs}, 0);

      // Simultaneous requests: data first, fetch afterwards
      i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      step();
      chk("simul_c1_addr", sram_addr, 32'h20);
      step();
      chk("simul_c2_acks", {d_ack, i_ack}, 2'b10);
      chk("simul_c2_drdata", d_rdata, 32'h0A0A0A0A);
      d_req = 1'b0;
      step();
      chk("simul_c3_acks", {d_ack, i_ack, sram_cs}, 0);
      step();
      chk("simul_c4_addr", {sram_cs, sram_addr}, {1'b1, 32'h30});
      step();
      chk("simul_c5_acks", {d_ack, i_ack}, 2'b01);
      chk("simul_c5_irdata", i_rdata, 32'h5A5A1234);
      i_req = 1'b0;
      step();

      // Write then read back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      n_we = 0;
      for (int c = 1; c <= 3; c++) begin
         step();
         if (sram_we) n_we++;
         if (c == 1) begin
            chk("wr_c1_bus", {sram_oe, sram_addr, sram_din}, {1'b0, 32'h40, 32'h12345678});
            d_req = 1'b0;
         end
         if (c == 2) begin
            chk("wr_c2_ack", d_ack, 1);
            chk("wr_drdata_kept", d_rdata, 32'h0A0A0A0A);
         end
      end
      chk("wr_we_cycles", n_we, 1);
      chk("wr_mem", mem[8'h40], 32'h12345678);
      d_req = 1'b1; d_we = 1'b0;
      step();
      d_req = 1'b0;
      step();
      chk("rd_back", {d_ack, d_rdata}, {1'b1, 32'h12345678});
      step();

      // Both requests held continuously for 40 cycles
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
      n_ack = 0; n_iack = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (i_ack || d_ack) begin
`ifdef ARB_STARVE_GUARD_EN
            chk("starve_order", i_ack, (n_ack % 5 == 4) ? 1 : 0);
`else
            chk("starve_order", i_ack, 0);
`endif
            n_ack++;
            if (i_ack) n_iack++;
         end
      end
      chk("starve_ack_count", n_ack, 13);
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_fetch_count", n_iack, 2);
`else
      chk("starve_fetch_count", n_iack, 0);
`endif
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) step();

      // Reset in the middle of a fetch access
      i_req = 1'b1; i_addr = 32'h10;
      step();
      chk("rstmid_c1_busy", {busy, sram_cs}, 2'b11);
      rst = 1'b1; i_req = 1'b0;
      step();
      chk("rstmid_c2", {i_ack, sram_cs, busy}, 0);
      chk("rstmid_c2_rdata", i_rdata, 0);
      rst = 1'b0;
      step();
      chk("rstmid_c3_noack", {i_ack, busy}, 0);

      // WAIT_CYCLES=3 instance
      w3_d_req = 1'b1; w3_d_addr = 32'h77;
      for (int c = 1; c <= 4; c++) begin
         step();
         w3_d_req = 1'b0;
         chk("w3_cs", {w3_sram_cs, w3_sram_oe}, (c <= 3) ? 2'b11 : 2'b00);
         chk("w3_ack", {w3_d_ack, w3_busy}, (c == 4) ? 2'b11 : 2'b01);
      end
      chk("w3_rdata", w3_d_rdata, 32'h77 ^ 32'hC3C3_0000);
      step();

      // Randomized traffic against a word-level memory model
      for (int k = 0; k < 256; k++) model[k] = mem[k];
      exp_i = '0; exp_d = '0; i_pend = 1'b0; d_pend = 1'b0;
      i_cool = 0; d_cool = 0; i_wait = 0; d_wait = 0;
      ia = '0; da = '0; dwd = '0; dwe = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         if (i_cool > 0) i_cool--;
         if (d_cool > 0) d_cool--;
         chk("one_ack", {i_ack & d_ack}, 0);
         if (i_ack) begin
            chk("i_ack_expected", i_pend, 1);
            exp_i = model[ia];
            i_pend = 1'b0; i_req = 1'b0; i_cool = 2;
         end
         if (d_ack) begin
            chk("d_ack_expected", d_pend, 1);
            if (dwe) begin
               model[da] = dwd;
               chk("sram_store", mem[da], dwd);
            end else begin
               exp_d = model[da];
            end
            d_pend = 1'b0; d_req = 1'b0; d_cool = 2;
         end
         chk("i_rdata", i_rdata, exp_i);
         chk("d_rdata", d_rdata, exp_d);
         if (sram_we) begin
            chk("we_is_store", {d_pend, dwe}, 2'b11);
            chk("we_bus", {sram_addr, sram_din}, {24'd0, da, dwd});
         end
         if (i_pend) begin
            i_wait++;
            chk("fetch_wait_bound", i_wait < 40, 1);
         end
         if (d_pend) begin
            d_wait++;
            chk("data_wait_bound", d_wait < 40, 1);
         end
         if (cyc < 2900) begin
            if (!i_pend && i_cool == 0 && $urandom_range(0, 2) == 0) begin
               ia = 8'($urandom); i_addr = {24'd0, ia};
               i_req = 1'b1; i_pend = 1'b1; i_wait = 0;
            end else if (!i_pend) begin
               i_addr = $urandom;
            end
            if (!d_pend && d_cool == 0 && $urandom_range(0, 2) == 0) begin
               da = 8'($urandom); dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
               d_addr = {24'd0, da}; d_we = dwe; d_wdata = dwd;
               d_req = 1'b1; d_pend = 1'b1; d_wait = 0;
            end else if (!d_pend) begin
               d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
            end
         end
      end
      chk("drained", {i_pend, d_pend, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
